// File: rtl/sum_ctrl.sv
// Control FSM for the 1..100 accumulate datapath: load/enable strobes,
// result capture, valid/ready output, abort and run-length watchdog.
module sum_ctrl #(
    parameter int RESULT_W = 13,
    parameter int TIMEOUT  = 255,
    parameter int TO_W     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic                dp_done,
    input  logic [RESULT_W-1:0] dp_result,
    output logic                dp_clr,
    output logic                ld_sum,
    output logic                ld_counter,
    output logic                en_sum,
    output logic                en_counter,
    output logic                busy,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [RESULT_W-1:0] out_data,
    output logic                err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RUN    = 3'd2,
        S_SETTLE = 3'd3,
        S_HOLD   = 3'd4,
        S_ERROR  = 3'd5
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] TO_MAX  = '1;

    state_t              state_q, state_d;
    logic [TO_W-1:0]     cnt_q, cnt_d;
    logic [RESULT_W-1:0] data_q, data_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) state_d = S_LOAD;
                end
                S_LOAD: begin
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
                S_RUN: begin
                    // saturate so a large TIMEOUT can never wrap the count
                    if (cnt_q != TO_MAX) cnt_d = cnt_q + 1'b1;
                    if (dp_done) state_d = S_SETTLE;
                    else if (cnt_q == TO_LAST) state_d = S_ERROR;
                end
                S_SETTLE: begin
                    data_d  = dp_result;
                    state_d = S_HOLD;
                end
                S_HOLD: begin
                    if (out_ready) state_d = S_IDLE;
                end
                S_ERROR: begin
                    if (start) state_d = S_LOAD;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign dp_clr     = (state_q == S_LOAD);
    assign ld_sum     = (state_q == S_LOAD);
    assign ld_counter = (state_q == S_LOAD);
    assign en_sum     = (state_q == S_RUN);
    assign en_counter = (state_q == S_RUN);
    assign busy       = (state_q == S_LOAD) || (state_q == S_RUN) ||
                        (state_q == S_SETTLE) || (state_q == S_HOLD);
    assign out_valid  = (state_q == S_HOLD);
    assign err        = (state_q == S_ERROR);
    assign out_data   = data_q;

endmodule

// File: doc/sum_ctrl.md
Name: sum_ctrl

Overview:
- Control-path FSM for the 13-bit accumulate datapath that sums 1..100.
- Drives the datapath's load and enable strobes and watches its done flag.
- Captures the datapath result one cycle after done and presents it on a valid/ready output handshake.
- Adds start/abort control, a busy flag and a run-length watchdog with an error flag.

Parameters:
RESULT_W, 13, width of dp_result and out_data
TIMEOUT, 255, maximum RUN-state cycles before the watchdog fires (1..2^TO_W-1)
TO_W, 8, width of the watchdog counter

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request a new summation; sampled only in IDLE and ERROR
abort  input  1  synchronous cancel; highest priority after rst
dp_done  input  1  done flag from the datapath
dp_result  input  RESULT_W  result register of the datapath
dp_clr  output  1  one-cycle clear pulse to the datapath (the integrator inverts it for the active-low datapath reset)
ld_sum  output  1  datapath sum load
ld_counter  output  1  datapath counter load
en_sum  output  1  datapath sum enable
en_counter  output  1  datapath counter enable
busy  output  1  high in LOAD, RUN, SETTLE, HOLD
out_valid  output  1  out_data holds a captured result
out_ready  input  1  consumer accepts out_data
out_data  output  RESULT_W  captured result
err  output  1  watchdog expired

Behaviour:
- Reset (rst=1, asynchronous): state=IDLE, watchdog counter=0, out_data=0, all outputs 0.
- All outputs decode from the state register or from registered data only; there is no combinational input-to-output path.
- States and their outputs:
  - IDLE: all strobes 0, busy=0. start=1 -> LOAD.
  - LOAD (exactly 1 cycle): dp_clr=ld_sum=ld_counter=1. Clears the watchdog counter. -> RUN.
  - RUN: en_sum=en_counter=1. Watchdog counter +1 per cycle. dp_done=1 -> SETTLE. Otherwise, when the counter reaches TIMEOUT-1 (i.e. the TIMEOUT-th RUN cycle) -> ERROR. If dp_done and the timeout occur in the same cycle, dp_done wins.
  - SETTLE (exactly 1 cycle, all strobes 0): the datapath registers its result one edge after done. At the exit edge, out_data <= dp_result. -> HOLD.
  - HOLD: out_valid=1, out_data stable. out_ready=1 -> IDLE; out_valid falls on the next cycle. start is ignored in HOLD.
  - ERROR: err=1, busy=0, strobes 0. start=1 -> LOAD (err clears). abort=1 -> IDLE.
- abort=1 in any non-IDLE state -> IDLE on the next edge.
  - out_valid and err drop.
  - out_data keeps its last value.
  - abort wins over start, dp_done, out_ready and the timeout.
- start while busy is ignored and not queued. A start pulse already present when the FSM returns to IDLE is honoured.
- Latency:
  - start edge -> LOAD the next cycle -> RUN the cycle after.
  - dp_done high in RUN -> out_valid high 2 cycles later.
- Every run re-clears the datapath through LOAD, so back-to-back runs never see a stale dp_done.
- Watchdog counter is TO_W bits and saturates rather than wrapping. It counts only in RUN.
- rst asserted mid-run: immediate return to reset values; any captured result is lost.

Test Plan:
- Nominal run: reset, pulse start with a behavioural datapath model attached -> exactly one LOAD cycle with dp_clr/ld_sum/ld_counter=1, then RUN. out_valid rises 2 cycles after dp_done with out_data=5050 (0x13BA); with out_ready=1, back to IDLE, busy=0.
- Backpressure: hold out_ready=0 for 10 cycles in HOLD, pulsing start -> out_valid and out_data=5050 stay stable, start is ignored. out_ready=1 -> IDLE the next cycle.
- Watchdog: dp_done tied 0, start -> err=1 after exactly 255 RUN cycles, strobes 0. A start pulse then -> LOAD, err=0.
- Abort: assert abort on RUN cycle 40 -> IDLE next edge, en_sum=en_counter=0. A fresh start gives out_data=5050.
- Simultaneity: dp_done and the timeout on the same cycle (TIMEOUT=5, dp_done on RUN cycle 5) -> SETTLE, not ERROR. abort together with out_ready in HOLD -> IDLE, out_data retained.
- Async reset: assert rst mid-RUN, between clock edges -> all outputs 0 immediately, state IDLE after release.
